// File: rtl/hex_decoder.sv
// -----------------------------------------------------------------------------
// hex_decoder
//
// Registered hexadecimal-to-seven-segment decoder for a common-anode display.
// Holds the last digit that was presented with in_valid. The digit can be
// overridden by blanking (all segments off) or by lamp test (all segments on).
// Every output is registered, so out follows its inputs one clock later and
// there is no combinational path from any input to out.
//
// Ports:
//   clk        in   1  system clock; all state changes on the rising edge
//   rst_n      in   1  synchronous active-low reset, sampled on the rising edge
//   in         in   4  binary digit to display, 0x0-0xF
//   in_valid   in   1  1 = capture `in` as the new held digit
//   blank      in   1  1 = all segments off
//   lamp_test  in   1  1 = all segments on (wins over blank)
//   out        out  7  active-low segment drive {g,f,e,d,c,b,a}; 0 = lit
//   out_valid  out  1  1 once at least one digit has been captured since reset
//
// Optional build macro HEX_DP_EN adds a decimal point:
//   dp_in      in   1  1 = point lit; captured together with the digit
//   dp_out     out  1  active-low point drive, same latency/overrides as out
// -----------------------------------------------------------------------------
module hex_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       in_valid,
  input  logic       blank,
  input  logic       lamp_test,
`ifdef HEX_DP_EN
  input  logic       dp_in,
  output logic       dp_out,
`endif
  output logic [6:0] out,
  output logic       out_valid
);

  localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ALL_ON  = 7'b0000000;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  // The default arm only matters for X/Z in simulation; all 16 codes are listed.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_ALL_OFF;
    endcase
    return seg;
  endfunction

  logic [3:0] r_digit;
  logic [6:0] r_out;
  logic       r_out_valid;

  logic [3:0] w_digit;
  logic       w_show;
  logic [6:0] w_out_next;

  // Select the digit to show and compute the next segment word.
  // A digit arriving this cycle is shown immediately, so the output latency
  // stays at one clock even on the very first capture.
  always_comb begin
    w_digit    = r_digit;
    w_show     = 1'b0;
    w_out_next = SEG_ALL_OFF;
    if (in_valid) begin
      w_digit = in;
    end else begin
      w_digit = r_digit;
    end
    w_show = r_out_valid | in_valid;
    if (lamp_test) begin
      w_out_next = SEG_ALL_ON;
    end else if (blank) begin
      w_out_next = SEG_ALL_OFF;
    end else if (!w_show) begin
      // Nothing captured since reset: keep the display dark.
      w_out_next = SEG_ALL_OFF;
    end else begin
      w_out_next = seg_decode(w_digit);
    end
  end

  // Held digit, valid flag and registered segment output.
  // Overrides never touch r_digit, so the digit comes back once they drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit     <= 4'h0;
      r_out_valid <= 1'b0;
      r_out       <= SEG_ALL_OFF;
    end else begin
      if (in_valid) begin
        r_digit     <= in;
        r_out_valid <= 1'b1;
      end else begin
        r_digit     <= r_digit;
        r_out_valid <= r_out_valid;
      end
      r_out <= w_out_next;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef HEX_DP_EN
  logic r_dp;
  logic r_dp_out;
  logic w_dp;
  logic w_dp_out_next;

  // Decimal point follows the same selection and override order as the digit.
  always_comb begin
    w_dp          = r_dp;
    w_dp_out_next = 1'b1;
    if (in_valid) begin
      w_dp = dp_in;
    end else begin
      w_dp = r_dp;
    end
    if (lamp_test) begin
      w_dp_out_next = 1'b0;
    end else if (blank) begin
      w_dp_out_next = 1'b1;
    end else if (!w_show) begin
      w_dp_out_next = 1'b1;
    end else begin
      w_dp_out_next = ~w_dp;
    end
  end

  // Held point and its registered active-low drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dp     <= 1'b0;
      r_dp_out <= 1'b1;
    end else begin
      if (in_valid) begin
        r_dp <= dp_in;
      end else begin
        r_dp <= r_dp;
      end
      r_dp_out <= w_dp_out_next;
    end
  end

  assign dp_out = r_dp_out;
`endif

endmodule

// File: tb/tb_hex_decoder.sv
// Directed bench for hex_decoder: inputs change on the falling edge, outputs
// are checked 1 time unit after the rising edge.
module tb_hex_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       in_valid;
  logic       blank;
  logic       lamp_test;
  logic [6:0] out;
  logic       out_valid;
`ifdef HEX_DP_EN
  logic       dp_in;
  logic       dp_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16];

  hex_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .blank     (blank),
    .lamp_test (lamp_test),
`ifdef HEX_DP_EN
    .dp_in     (dp_in),
    .dp_out    (dp_out),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then advance past the next rising edge.
  task automatic step(input logic rn, input logic [3:0] d, input logic v,
                      input logic bl, input logic lt);
    @(negedge clk);
    rst_n     = rn;
    in        = d;
    in_valid  = v;
    blank     = bl;
    lamp_test = lt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    rst_n = 1'b0; in = 4'h8; in_valid = 1'b1; blank = 1'b0; lamp_test = 1'b0;
`ifdef HEX_DP_EN
    dp_in = 1'b1;
`endif

    // Reset held for two edges with a capture request pending.
    step(1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
    chk("reset_out", {1'b0, out}, 8'h7F);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
`ifdef HEX_DP_EN
    chk("reset_dp", {7'd0, dp_out}, 8'h01);
    dp_in = 1'b0;
`endif

    // Released, nothing captured yet: stays dark.
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    chk("idle_out", {1'b0, out}, 8'h7F);
    chk("idle_valid", {7'd0, out_valid}, 8'h00);

    // Full sweep, one capture per cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("sweep_%0h", i), {1'b0, out}, {1'b0, seg_tab[i]});
      chk($sformatf("sweep_valid_%0h", i), {7'd0, out_valid}, 8'h01);
    end

    // Hold: capture A, then ignore in while in_valid is low.
    step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    chk("hold_cap", {1'b0, out}, {1'b0, 7'b0001000});
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    chk("hold_1", {1'b0, out}, {1'b0, 7'b0001000});
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    chk("hold_2", {1'b0, out}, {1'b0, 7'b0001000});

    // Overrides over held digit 2.
    step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    chk("ovr_cap2", {1'b0, out}, {1'b0, 7'b0100100});
    step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    chk("ovr_blank", {1'b0, out}, 8'h7F);
    step(1'b1, 4'h9, 1'b0, 1'b1, 1'b1);
    chk("ovr_lamp_blank", {1'b0, out}, 8'h00);
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    chk("ovr_release", {1'b0, out}, {1'b0, 7'b0100100});

    // Capture during blank: digit still taken, shown after release.
    step(1'b1, 4'h4, 1'b1, 1'b1, 1'b0);
    chk("cap_blank", {1'b0, out}, 8'h7F);
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("cap_blank_rel", {1'b0, out}, {1'b0, 7'b0011001});

    // Mid-operation reset.
    step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    chk("mid_cap5", {1'b0, out}, {1'b0, 7'b0010010});
    step(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_out", {1'b0, out}, 8'h7F);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    chk("mid_idle_out", {1'b0, out}, 8'h7F);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("mid_lamp_novalid", {1'b0, out}, 8'h00);
    step(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    chk("mid_cap1", {1'b0, out}, {1'b0, 7'b1111001});
    chk("mid_cap1_valid", {7'd0, out_valid}, 8'h01);

`ifdef HEX_DP_EN
    // Decimal point captured with the digit, overridden by blank.
    dp_in = 1'b1;
    step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("dp_cap_out", {1'b0, out}, {1'b0, 7'b1000000});
    chk("dp_cap", {7'd0, dp_out}, 8'h00);
    dp_in = 1'b0;
    step(1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("dp_blank", {7'd0, dp_out}, 8'h01);
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("dp_held", {7'd0, dp_out}, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
